wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_arb_pkg.sv | 21 ++
 rtl/wb_arb_fifo.sv | 59 +++++
 rtl/wb_port_arbiter.sv | 133 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the writeback port arbiter and its result queue.
package wb_arb_pkg;

    // Arbiter modes: queue empty, pipeline-priority with queued work, forced drain.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int FIFO_DEPTH_DEF   = 2;

    localparam int RD_W    = 5;
    localparam int DATA_W  = 32;
    // One queued result is {rd, data}.
    localparam int ENTRY_W = RD_W + DATA_W;
    // Occupancy counter width, sized for the default depth.
    localparam int CNT_W   = 2;

endpackage

// File: rtl/wb_arb_fifo.sv
// Small FIFO holding multi-cycle results waiting for a free register-file write port.
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] dout,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    // Pointers wrap explicitly so non-power-of-two depths stay correct.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Control state: pointers and occupancy, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the writeback stage and
// queued multi-cycle results, forcing a one-cycle drain when the queue starves.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_rf_wb,
    input  logic [RD_W-1:0]   pipe_rd,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              mcu_valid,
    input  logic [RD_W-1:0]   mcu_rd,
    input  logic [DATA_W-1:0] mcu_data,
    output logic              mcu_ready,
    output logic              rf_we,
    output logic [RD_W-1:0]   rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pipe_stall,
    output logic [CNT_W-1:0]  q_count
);

    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [STV_W-1:0]   starve_cnt;
    logic [STV_W-1:0]   starve_nxt;

    logic               pv;
    logic               sel_pipe;
    logic               sel_head;
    logic               pop;
    logic               enq;
    logic               q_full;
    logic               q_empty;
    logic               q_last;
    logic [ENTRY_W-1:0] head;

    // A full queue never accepts, even if it pops this cycle; x0 results are
    // acknowledged but never stored.
    assign mcu_ready = !q_full;
    assign enq       = mcu_valid && mcu_ready && (mcu_rd != '0);
    assign pop       = sel_head;
    assign q_last    = (q_count == CNT_W'(1));

    wb_arb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (enq),
        .pop   (pop),
        .din   ({mcu_rd, mcu_data}),
        .dout  (head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // State register; the stall flag is registered from the next state so it
    // is high exactly for cycles spent in DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            pipe_stall <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            pipe_stall <= (state_nxt == ST_DRAIN);
        end
    end

    // Next-state and starvation bookkeeping.
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        case (state)
            ST_IDLE: begin
                if (enq) state_nxt = ST_PEND;
            end
            ST_PEND: begin
                if (pop && q_last && !enq)
                    state_nxt = ST_IDLE;
                else if (sel_pipe && (starve_cnt == STV_W'(STARVE_LIMIT - 1)))
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // The drain pops exactly one entry, then pipeline priority resumes.
                if (q_empty || (q_last && !enq))
                    state_nxt = ST_IDLE;
                else
                    state_nxt = ST_PEND;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (state_nxt == ST_IDLE || pop)
            starve_nxt = '0;
        else if (state == ST_PEND && sel_pipe && starve_cnt < STV_W'(STARVE_LIMIT))
            starve_nxt = starve_cnt + STV_W'(1);
    end

    // Port select and write-port drive; unused fields are held at zero.
    always_comb begin
        pv       = pipe_rf_wb && (pipe_rd != '0) && !pipe_stall;
        sel_pipe = 1'b0;
        sel_head = 1'b0;
        case (state)
            ST_IDLE:  sel_pipe = pv;
            ST_PEND: begin
                if (pv) sel_pipe = 1'b1;
                else    sel_head = !q_empty;
            end
            ST_DRAIN: sel_head = !q_empty;
            default:  sel_pipe = 1'b0;
        endcase

        rf_we    = sel_pipe || sel_head;
        rf_rd    = '0;
        rf_wdata = '0;
        if (sel_pipe) begin
            rf_rd    = pipe_rd;
            rf_wdata = pipe_data;
        end else if (sel_head) begin
            {rf_rd, rf_wdata} = head;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_wb_port_arbiter;

    localparam int LIMIT = 4;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pipe_rf_wb = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [31:0] pipe_data = '0;
    logic        mcu_valid = 1'b0;
    logic [4:0]  mcu_rd = '0;
    logic [31:0] mcu_data = '0;
    logic        mcu_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic        pipe_stall;
    logic [1:0]  q_count;

    int n_cmp = 0;
    int n_fail = 0;

    wb_port_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_rf_wb (pipe_rf_wb),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .mcu_valid  (mcu_valid),
        .mcu_rd     (mcu_rd),
        .mcu_data   (mcu_data),
        .mcu_ready  (mcu_ready),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wdata   (rf_wdata),
        .pipe_stall (pipe_stall),
        .q_count    (q_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: a queue of {rd,data}, a "draining" flag and a count of
    // consecutive pipeline wins while results wait.
    logic [36:0] mq[$];
    int          m_starve;
    bit          m_drain;
    bit          e_we, e_pop, e_pvwin, e_ready, e_stall;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    int          e_cnt;

    task automatic drive(input bit wb, input logic [4:0] rd, input logic [31:0] d,
                         input bit mv, input logic [4:0] mrd, input logic [31:0] md);
        pipe_rf_wb = wb; pipe_rd = rd; pipe_data = d;
        mcu_valid = mv; mcu_rd = mrd; mcu_data = md;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mq.delete(); m_starve = 0; m_drain = 0;
    endtask

    task automatic model_eval();
        bit pv;
        logic [36:0] h;
        pv = pipe_rf_wb && pipe_rd != 0 && !m_drain;
        e_ready = (mq.size() != DEPTH);
        e_cnt = mq.size();
        e_stall = m_drain;
        e_we = 0; e_rd = 0; e_data = 0; e_pop = 0; e_pvwin = 0;
        if (m_drain || (!pv && mq.size() > 0)) begin
            h = mq[0];
            e_we = 1; e_rd = h[36:32]; e_data = h[31:0]; e_pop = 1;
        end else if (pv) begin
            e_we = 1; e_rd = pipe_rd; e_data = pipe_data; e_pvwin = 1;
        end
    endtask

    task automatic model_commit();
        bit had_work, was_full, nxt_drain;
        had_work = mq.size() > 0;
        was_full = mq.size() == DEPTH;
        nxt_drain = 0;
        if (!m_drain && e_pvwin && had_work) begin
            if (m_starve == LIMIT - 1) nxt_drain = 1;
            m_starve++;
        end
        if (e_pop) begin
            void'(mq.pop_front());
            m_starve = 0;
        end
        if (mcu_valid && !was_full && mcu_rd != 0) mq.push_back({mcu_rd, mcu_data});
        if (mq.size() == 0) m_starve = 0;
        m_drain = nxt_drain;
    endtask

    task automatic test_reset();
        apply_reset();
        drive(0, 0, 0, 1, 5'd4, 32'h1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        n_cmp++; if (q_count !== 2'd0) begin n_fail++; $display("FAIL reset_qcount got %0d want 0", q_count); end
        n_cmp++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", pipe_stall); end
        n_cmp++; if (mcu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", mcu_ready); end
        n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we_idle got %b want 0", rf_we); end
        drive(1, 5'd5, 32'h77, 0, 0, 0);
        #1;
        n_cmp++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL reset_we_pipe got %b want 1", rf_we); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_idle_pass();
        apply_reset();
        drive(1, 5'd5, 32'hA5A5A5A5, 0, 0, 0);
        #1;
        n_cmp++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL idle_we got %b want 1", rf_we); end
        n_cmp++; if (rf_rd !== 5'd5) begin n_fail++; $display("FAIL idle_rd got %0d want 5", rf_rd); end
        n_cmp++; if (rf_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL idle_data got %h want a5a5a5a5", rf_wdata); end
        n_cmp++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL idle_stall got %b want 0", pipe_stall); end
    endtask

    task automatic test_gap_fill();
        apply_reset();
        drive(0, 0, 0, 1, 5'd7, 32'h1234);
        #1;
        n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL gap_nobypass got %b want 0", rf_we); end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL gap_we got %b want 1", rf_we); end
        n_cmp++; if (rf_rd !== 5'd7) begin n_fail++; $display("FAIL gap_rd got %0d want 7", rf_rd); end
        n_cmp++; if (rf_wdata !== 32'h1234) begin n_fail++; $display("FAIL gap_data got %h want 1234", rf_wdata); end
        @(negedge clk);
        #1;
        n_cmp++; if (q_count !== 2'd0) begin n_fail++; $display("FAIL gap_qcount got %0d want 0", q_count); end
        n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL gap_idle_we got %b want 0", rf_we); end
    endtask

    task automatic test_starvation();
        apply_reset();
        drive(1, 5'd3, 32'hC0DE, 1, 5'd9, 32'hDEAD);
        #1;
        n_cmp++; if (rf_rd !== 5'd3) begin n_fail++; $display("FAIL starve_push_rd got %0d want 3", rf_rd); end
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk);
            drive(1, 5'd3, 32'hC0DE, 0, 0, 0);
            #1;
            n_cmp++; if (rf_rd !== 5'd3 || pipe_stall !== 1'b0) begin n_fail++; $display("FAIL starve_pipe%0d got rd=%0d stall=%b want rd=3 stall=0", i, rf_rd, pipe_stall); end
        end
        @(negedge clk);
        #1;
        n_cmp++; if (pipe_stall !== 1'b1) begin n_fail++; $display("FAIL starve_stall got %b want 1", pipe_stall); end
        n_cmp++; if (rf_rd !== 5'd9 || rf_wdata !== 32'hDEAD) begin n_fail++; $display("FAIL starve_drain got rd=%0d data=%h want rd=9 data=dead", rf_rd, rf_wdata); end
        @(negedge clk);
        #1;
        n_cmp++; if (pipe_stall !== 1'b0 || rf_rd !== 5'd3 || q_count !== 2'd0) begin n_fail++; $display("FAIL starve_after got stall=%b rd=%0d q=%0d want 0/3/0", pipe_stall, rf_rd, q_count); end
    endtask

    task automatic test_full_queue();
        bit seen;
        apply_reset();
        drive(1, 5'd3, 32'h3, 1, 5'd10, 32'hA);
        #1;
        n_cmp++; if (mcu_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready0 got %b want 1", mcu_ready); end
        @(negedge clk);
        drive(1, 5'd3, 32'h3, 1, 5'd11, 32'hB);
        #1;
        n_cmp++; if (mcu_ready !== 1'b1 || q_count !== 2'd1) begin n_fail++; $display("FAIL full_ready1 got rdy=%b q=%0d want 1/1", mcu_ready, q_count); end
        @(negedge clk);
        drive(1, 5'd3, 32'h3, 1, 5'd12, 32'hC);
        #1;
        n_cmp++; if (mcu_ready !== 1'b0 || q_count !== 2'd2) begin n_fail++; $display("FAIL full_ready2 got rdy=%b q=%0d want 0/2", mcu_ready, q_count); end
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (pipe_stall) seen = 1;
            else begin
                n_cmp++; if (mcu_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold got %b want 0", mcu_ready); end
            end
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL full_drain_timeout got stall=%b want 1", pipe_stall); end
        n_cmp++; if (rf_rd !== 5'd10 || rf_wdata !== 32'hA || mcu_ready !== 1'b0) begin n_fail++; $display("FAIL full_drain got rd=%0d data=%h rdy=%b want 10/a/0", rf_rd, rf_wdata, mcu_ready); end
        @(negedge clk);
        #1;
        n_cmp++; if (mcu_ready !== 1'b1 || q_count !== 2'd1 || rf_rd !== 5'd3) begin n_fail++; $display("FAIL full_accept got rdy=%b q=%0d rd=%0d want 1/1/3", mcu_ready, q_count, rf_rd); end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (q_count !== 2'd2 || rf_rd !== 5'd11 || rf_wdata !== 32'hB) begin n_fail++; $display("FAIL full_order1 got q=%0d rd=%0d data=%h want 2/11/b", q_count, rf_rd, rf_wdata); end
        @(negedge clk);
        #1;
        n_cmp++; if (q_count !== 2'd1 || rf_rd !== 5'd12 || rf_wdata !== 32'hC) begin n_fail++; $display("FAIL full_order2 got q=%0d rd=%0d data=%h want 1/12/c", q_count, rf_rd, rf_wdata); end
        @(negedge clk);
        #1;
        n_cmp++; if (q_count !== 2'd0 || rf_we !== 1'b0) begin n_fail++; $display("FAIL full_empty got q=%0d we=%b want 0/0", q_count, rf_we); end
    endtask

    task automatic test_x0_filter();
        apply_reset();
        drive(1, 5'd0, 32'hFFFF, 1, 5'd0, 32'hEEEE);
        #1;
        n_cmp++; if (rf_we !== 1'b0 || mcu_ready !== 1'b1) begin n_fail++; $display("FAIL x0_we got we=%b rdy=%b want 0/1", rf_we, mcu_ready); end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (q_count !== 2'd0 || rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_queue got q=%0d we=%b want 0/0", q_count, rf_we); end
    endtask

    task automatic test_reset_drain();
        bit seen;
        apply_reset();
        drive(1, 5'd3, 32'h3, 1, 5'd20, 32'h20);
        @(negedge clk);
        drive(1, 5'd3, 32'h3, 1, 5'd21, 32'h21);
        @(negedge clk);
        drive(1, 5'd3, 32'h3, 0, 0, 0);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (pipe_stall) seen = 1;
        end
        n_cmp++; if (!seen || q_count !== 2'd2) begin n_fail++; $display("FAIL rstdrain_setup got stall=%b q=%0d want 1/2", pipe_stall, q_count); end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (pipe_stall !== 1'b0 || q_count !== 2'd0 || mcu_ready !== 1'b1) begin n_fail++; $display("FAIL rstdrain_clear got stall=%b q=%0d rdy=%b want 0/0/1", pipe_stall, q_count, mcu_ready); end
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rstdrain_nowrite%0d got we=%b rd=%0d want 0", k, rf_we, rf_rd); end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [4:0] rd, mrd;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            mrd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            drive($urandom_range(0, 9) < 7, rd, $urandom, $urandom_range(0, 9) < 4, mrd, $urandom);
            #1;
            model_eval();
            n_cmp++; if (rf_we !== e_we || rf_rd !== e_rd || rf_wdata !== e_data) begin n_fail++; $display("FAIL rand_port c%0d got we=%b rd=%0d data=%h want we=%b rd=%0d data=%h", c, rf_we, rf_rd, rf_wdata, e_we, e_rd, e_data); end
            n_cmp++; if (pipe_stall !== e_stall || mcu_ready !== e_ready || q_count !== 2'(e_cnt)) begin n_fail++; $display("FAIL rand_ctrl c%0d got stall=%b rdy=%b q=%0d want stall=%b rdy=%b q=%0d", c, pipe_stall, mcu_ready, q_count, e_stall, e_ready, e_cnt); end
            @(posedge clk);
            model_commit();
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_idle_pass();
        test_gap_fill();
        test_starvation();
        test_full_queue();
        test_x0_filter();
        test_reset_drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
